inst_fetch_buffer: RTL and testbench
====================================

// Module: inst_fetch_buffer
// PURPOSE
//  Instruction fetch stage sitting directly downstream of the PC stage. Accepts fetch addresses
//  (pc, ce), issues in-order requests to instruction memory, and collects responses into a
//  DEPTH-entry queue of {pc, inst} pairs. Delivers pairs to decode over a valid/ready handshake.
//  pc_ready_o drives the PC stage's stall; flush_i (branch/exception) discards all fetched work.
// PARAMETERS
//  DEPTH   4   queue entries = max slots reserved + in flight; power of 2, >=2
//  ADDR_W  32  instruction address width (`InstAddrBus)
//  DATA_W  32  instruction width (`InstBus)
// PORTS
//  clk          in   1       clock, all state on posedge
//  rst          in   1       synchronous reset, active-high
//  pc_i         in   ADDR_W  fetch address from the PC stage
//  ce_i         in   1       fetch address valid (`ChipEnable)
//  pc_ready_o   out  1       fetch address accepted this cycle; PC stage advances only when high
//  flush_i      in   1       discard queue and all in-flight responses
//  imem_req_o   out  1       memory request valid
//  imem_addr_o  out  ADDR_W  memory request address (= pc_i)
//  imem_gnt_i   in   1       memory accepts request this cycle
//  imem_rvalid_i in  1       response valid; responses return in request order, latency >=1
//  imem_rdata_i in   DATA_W  response instruction
//  id_valid_o   out  1       decode output valid
//  id_pc_o      out  ADDR_W  pc of head instruction; 0 when !id_valid_o
//  id_inst_o    out  DATA_W  head instruction; 0 (NOP) when !id_valid_o
//  id_ready_i   in   1       decode consumes head this cycle
// BEHAVIOUR
//  - Storage: DEPTH entries {pc, inst}; three pointers, log2(DEPTH)+1 bits with wrap bit:
//    alloc_ptr (reserved at grant), fill_ptr (response written), rd_ptr (popped).
//    occupancy = alloc_ptr-rd_ptr; outstanding = alloc_ptr-fill_ptr; drop_cnt 0..DEPTH.
//  - space = (occupancy + drop_cnt) < DEPTH, from registered state only; no same-cycle pop bypass.
//  - imem_req_o = !rst & ce_i & space & !flush_i; imem_addr_o = pc_i.
//  - pc_ready_o = imem_req_o & imem_gnt_i. On it: entry[alloc_ptr].pc <= pc_i, alloc_ptr++.
//  - imem_rvalid_i: if drop_cnt>0, drop_cnt-- and data discarded; else entry[fill_ptr].inst <=
//    imem_rdata_i, fill_ptr++. rvalid with outstanding==0 and drop_cnt==0 is a protocol error:
//    ignored, flagged by assertion.
//  - id_valid_o = (rd_ptr != fill_ptr); outputs driven from entry[rd_ptr] (registered storage).
//    Pop when id_valid_o & id_ready_i: rd_ptr++.
//  - Latency: grant at cycle t, rvalid at t+L (L>=1), id_valid_o at t+L+1. Max 1 pop/cycle.
//  - Flush (highest priority): alloc/fill/rd_ptr <= 0; drop_cnt <= drop_cnt + outstanding -
//    (rvalid this cycle & drop_cnt==0 ? 1 : 0) net of any same-cycle drop decrement; no request
//    and no pop that cycle; id_valid_o=0 the following cycle. Requests resume next cycle if space.
//  - Full (occupancy+drop_cnt==DEPTH): imem_req_o=0, pc_ready_o=0 until a pop or drop frees a slot.
//  - Reset: all pointers and drop_cnt 0; id_valid_o=0, id_pc_o=0, id_inst_o=0, imem_req_o=0,
//    pc_ready_o=0. Memory subsystem shares rst; rvalid during rst ignored. Mid-operation reset
//    abandons everything, no drain.
// STRUCTURE
//  - Widths and enables (`InstAddrBus, `InstBus, `ChipEnable, `RstEnable, NOP = 32'h0) come
//    from the shared defines.v header; DEPTH-derived pointer width computed locally.
//  - Single module; no sub-module (three-pointer scoreboard does not map onto a plain FIFO).
// TESTING
//  1. rst=1 for 3 cycles, ce_i=1, gnt=1 -> id_valid_o=0, imem_req_o=0, pc_ready_o=0 throughout.
//  2. pc_i=0x0 granted at t, rvalid t+1 rdata=0x3C010001 -> id_valid_o at t+2, id_pc_o=0x0,
//     id_inst_o=0x3C010001; pop with id_ready_i=1 -> id_valid_o=0 at t+3.
//  3. id_ready_i=0, gnt=1, L=1, pc 0,4,8,C,10.. -> exactly 4 grants then imem_req_o=0;
//     raise id_ready_i -> pops 0x0,0x4,0x8,0xC in order, one new grant per freed slot.
//  4. L=3, 2 outstanding, flush_i pulse -> id_valid_o=0 next cycle, next 2 rvalids dropped;
//     pc 0x100 granted after flush delivered with its own rdata, never a stale instruction.
//  5. flush_i coincident with rvalid of 1 of 3 outstanding -> drop_cnt=2; exactly 2 further
//     responses discarded, third post-flush response delivered.
//  6. Random gnt stalls, random L in 1..4, random id_ready_i, 1000 fetches -> scoreboard:
//     in-order {pc,inst} match, no loss/duplication, occupancy+drop_cnt never > DEPTH.

Source files
------------

// File: rtl/inst_fetch_buffer_pkg.sv
// Shared widths and types for the instruction fetch buffer.
// The fetch queue stores one {pc, inst} pair per slot.
package inst_fetch_buffer_pkg;

  localparam int unsigned InstAddrW = 32;
  localparam int unsigned InstW     = 32;

  localparam logic [InstW-1:0] Nop = '0;

  typedef struct packed {
    logic [InstAddrW-1:0] pc;
    logic [InstW-1:0]     inst;
  } fetch_pair_t;

endpackage

// File: rtl/inst_fetch_buffer_if.sv
// Fetch-stage bundle: PC-stage handshake, instruction memory request/response, decode output.
// The buffer takes the slave side; its environment (PC stage, memory, decode) the master side.
interface inst_fetch_buffer_if;
  import inst_fetch_buffer_pkg::*;

  logic [InstAddrW-1:0] pc;
  logic                 ce;
  logic                 pc_ready;
  logic                 flush;
  logic                 imem_req;
  logic [InstAddrW-1:0] imem_addr;
  logic                 imem_gnt;
  logic                 imem_rvalid;
  logic [InstW-1:0]     imem_rdata;
  logic                 id_valid;
  logic [InstAddrW-1:0] id_pc;
  logic [InstW-1:0]     id_inst;
  logic                 id_ready;

  modport master (
    output pc, ce, flush, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    input  pc_ready, imem_req, imem_addr, id_valid, id_pc, id_inst
  );

  modport slave (
    input  pc, ce, flush, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    output pc_ready, imem_req, imem_addr, id_valid, id_pc, id_inst
  );

endinterface

// File: rtl/inst_fetch_buffer.sv
// Fetch buffer: slots are reserved at grant, filled by in-order memory responses and popped
// to decode. Responses still in flight at a flush are counted off and discarded.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input logic                clk,
  input logic                rst,
  inst_fetch_buffer_if.slave bus
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned PtrW = IdxW + 1;

  typedef logic [PtrW-1:0] ptr_t;

  localparam ptr_t PtrOne = ptr_t'(1);

  ptr_t alloc_q, alloc_d;
  ptr_t fill_q, fill_d;
  ptr_t rd_q, rd_d;
  ptr_t drop_q, drop_d;

  fetch_pair_t [Depth-1:0] mem_q, mem_d;

  ptr_t          occupancy;
  ptr_t          outstanding;
  logic [PtrW:0] used;
  logic          space;
  logic          req;
  logic          grant;
  logic          rvalid_ok;
  logic          drop_now;
  logic          fill_now;
  logic          id_valid;
  logic          pop;

  always_comb begin
    occupancy   = alloc_q - rd_q;
    outstanding = alloc_q - fill_q;
    used        = {1'b0, occupancy} + {1'b0, drop_q};
    // Registered state only: a same-cycle pop does not open a slot.
    space       = used < (PtrW + 1)'(Depth);
    req         = !rst && bus.ce && space && !bus.flush;
    grant       = req && bus.imem_gnt;
    // A response with nothing outstanding or pending drop is a protocol error and is ignored.
    rvalid_ok   = !rst && bus.imem_rvalid && (outstanding != '0 || drop_q != '0);
    drop_now    = rvalid_ok && (drop_q != '0);
    fill_now    = rvalid_ok && (drop_q == '0);
    id_valid    = !rst && (rd_q != fill_q);
    pop         = id_valid && bus.id_ready && !bus.flush;
  end

  always_comb begin
    alloc_d = alloc_q;
    fill_d  = fill_q;
    rd_d    = rd_q;
    drop_d  = drop_q;
    mem_d   = mem_q;

    if (grant) begin
      mem_d[alloc_q[IdxW-1:0]].pc = bus.pc;
      alloc_d                     = alloc_q + PtrOne;
    end
    if (fill_now) begin
      mem_d[fill_q[IdxW-1:0]].inst = bus.imem_rdata;
      fill_d                       = fill_q + PtrOne;
    end
    if (drop_now) begin
      drop_d = drop_q - PtrOne;
    end
    if (pop) begin
      rd_d = rd_q + PtrOne;
    end

    // Everything still in flight becomes a drop, less any response consumed this cycle.
    if (bus.flush) begin
      alloc_d = '0;
      fill_d  = '0;
      rd_d    = '0;
      drop_d  = drop_q + outstanding - ptr_t'(rvalid_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q <= '0;
      fill_q  <= '0;
      rd_q    <= '0;
      drop_q  <= '0;
    end else begin
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      rd_q    <= rd_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = bus.pc;
  assign bus.pc_ready  = grant;
  assign bus.id_valid  = id_valid;
  assign bus.id_pc     = id_valid ? mem_q[rd_q[IdxW-1:0]].pc : '0;
  assign bus.id_inst   = id_valid ? mem_q[rd_q[IdxW-1:0]].inst : Nop;

  prot_rvalid_a : assert property (@(posedge clk) disable iff (rst)
    bus.imem_rvalid |-> (outstanding != '0 || drop_q != '0));

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed plus random bench for inst_fetch_buffer: a queue-level model of the fetch buffer
// and an in-order memory model are stepped every cycle and compared against the DUT outputs.
module tb_inst_fetch_buffer;

  localparam int Depth = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          filled;
  } slot_t;

  typedef struct {
    logic [31:0] pc;
    int          due;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  inst_fetch_buffer_if bus ();

  inst_fetch_buffer #(.Depth(Depth)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int lat  = 1;
  int last_due = 0;

  slot_t mq[$];
  int    drop = 0;
  resp_t pend[$];

  logic        s_req, s_rdy, s_valid;
  logic [31:0] s_pc, s_inst;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'h3C01_0001 ^ (pc * 32'h0100_0193);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle(input logic r, input logic ce, input logic [31:0] pc, input logic gnt,
                       input logic fl, input logic rdy);
    logic        rv;
    logic [31:0] rd;
    logic        e_req, e_rdy, e_valid;
    logic [31:0] e_pc, e_inst;
    int          unfilled;
    int          due;
    @(negedge clk);
    rv = !r && pend.size() > 0 && pend[0].due <= cyc;
    rd = rv ? inst_of(pend[0].pc) : 32'hDEAD_BEEF;
    rst             = r;
    bus.ce          = ce;
    bus.pc          = pc;
    bus.imem_gnt    = gnt;
    bus.flush       = fl;
    bus.id_ready    = rdy;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    #1;
    e_req   = !r && ce && (mq.size() + drop < Depth) && !fl;
    e_rdy   = e_req && gnt;
    e_valid = !r && mq.size() > 0 && mq[0].filled;
    e_pc    = e_valid ? mq[0].pc : 32'h0;
    e_inst  = e_valid ? mq[0].inst : 32'h0;
    s_req   = bus.imem_req;
    s_rdy   = bus.pc_ready;
    s_valid = bus.id_valid;
    s_pc    = bus.id_pc;
    s_inst  = bus.id_inst;
    chk("imem_req", {31'b0, s_req}, {31'b0, e_req});
    chk("pc_ready", {31'b0, s_rdy}, {31'b0, e_rdy});
    chk("imem_addr", bus.imem_addr, pc);
    chk("id_valid", {31'b0, s_valid}, {31'b0, e_valid});
    chk("id_pc", s_pc, e_pc);
    chk("id_inst", s_inst, e_inst);
    if (r) begin
      mq.delete();
      drop = 0;
      pend.delete();
    end else begin
      if (rv) begin
        if (drop > 0) drop--;
        else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled) begin
              mq[i].inst   = rd;
              mq[i].filled = 1'b1;
              break;
            end
          end
        end
        void'(pend.pop_front());
      end
      if (fl) begin
        unfilled = 0;
        foreach (mq[i]) if (!mq[i].filled) unfilled++;
        drop += unfilled;
        mq.delete();
      end else begin
        if (e_valid && rdy) void'(mq.pop_front());
        if (e_rdy) mq.push_back('{pc: pc, inst: 32'h0, filled: 1'b0});
      end
      if (e_rdy) begin
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = due;
        pend.push_back('{pc: pc, due: due});
      end
      if (mq.size() + drop > Depth) begin
        errs++;
        $display("FAIL model_capacity: got %0d, expected <= %0d", mq.size() + drop, Depth);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, rdy);
  endtask

  initial begin
    logic [31:0] pcv;
    logic [31:0] popped[$];
    int grants;
    int fetched;
    int k;

    // 1: reset held with a live fetch address
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("t1_req", {31'b0, s_req}, 32'h0);
      chk("t1_valid", {31'b0, s_valid}, 32'h0);
    end

    // 2: single fetch, L=1
    lat = 1;
    cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("t2_grant", {31'b0, s_rdy}, 32'h1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("t2_valid_t1", {31'b0, s_valid}, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("t2_valid_t2", {31'b0, s_valid}, 32'h1);
    chk("t2_pc", s_pc, 32'h0);
    chk("t2_inst", s_inst, 32'h3C01_0001);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("t2_valid_t3", {31'b0, s_valid}, 32'h0);

    // 3: fill up with decode stalled, then drain
    pcv = 32'h0;
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, pcv, 1'b1, 1'b0, 1'b0);
      if (s_rdy) begin
        grants++;
        pcv += 32'h4;
      end
    end
    chk("t3_grants", grants, 4);
    chk("t3_req_full", {31'b0, s_req}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, pcv, 1'b1, 1'b0, 1'b1);
      if (s_valid) popped.push_back(s_pc);
      if (s_rdy) pcv += 32'h4;
    end
    chk("t3_pop0", popped[0], 32'h0);
    chk("t3_pop1", popped[1], 32'h4);
    chk("t3_pop2", popped[2], 32'h8);
    chk("t3_pop3", popped[3], 32'hC);
    idle(12, 1'b1);

    // 4: flush with two responses in flight, L=3
    lat = 3;
    cycle(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    chk("t4_valid_after_flush", {31'b0, s_valid}, 32'h0);
    chk("t4_grant_100", {31'b0, s_rdy}, 32'h1);
    k = 0;
    do begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      k++;
    end while (!s_valid && k < 20);
    chk("t4_valid", {31'b0, s_valid}, 32'h1);
    chk("t4_pc", s_pc, 32'h100);
    chk("t4_inst", s_inst, inst_of(32'h100));
    idle(8, 1'b1);

    // 5: flush coincident with the first of three responses
    cycle(1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h84, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h88, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
    chk("t5_grant_200", {31'b0, s_rdy}, 32'h1);
    k = 0;
    do begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      k++;
    end while (!s_valid && k < 20);
    chk("t5_pc", s_pc, 32'h200);
    chk("t5_inst", s_inst, inst_of(32'h200));
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

    // mid-operation reset abandons in-flight work
    lat = 2;
    cycle(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h304, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h304, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    chk("rst_valid", {31'b0, s_valid}, 32'h0);

    // 6: random stalls, latencies, decode back-pressure and occasional flushes
    pcv = 32'h1000;
    fetched = 0;
    k = 0;
    while (fetched < 1000 && k < 20000) begin
      logic fl;
      lat = $urandom_range(1, 4);
      fl = ($urandom_range(0, 63) == 0);
      cycle(1'b0, $urandom_range(0, 9) != 0, pcv, $urandom_range(0, 3) != 0, fl,
            $urandom_range(0, 2) != 0);
      if (fl) pcv = {$urandom_range(0, 16'hFFFF), 2'b00};
      else if (s_rdy) begin
        fetched++;
        pcv += 32'h4;
      end
      k++;
    end
    chk("t6_fetched", fetched, 1000);
    idle(10, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
